regfile_port_sched: RTL



---
 rtl/regfile_port_sched_if.sv | 41 ++++
 rtl/regfile_port_sched.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/regfile_port_sched_if.sv
// Write-request bundle for the register file port scheduler.
// Three requesters share one valid/ready handshake group.
`ifndef REG_SELECT_DEFINED
`define REG_SELECT_DEFINED
`define REG_SEL logic [3:0]
`endif

interface regfile_port_sched_if #(
    parameter int DATA_W = 16
);
    logic [2:0]        req_valid;
    `REG_SEL           req_dest0;
    `REG_SEL           req_dest1;
    `REG_SEL           req_dest2;
    logic [DATA_W-1:0] req_data0;
    logic [DATA_W-1:0] req_data1;
    logic [DATA_W-1:0] req_data2;
    logic [2:0]        req_ready;

    modport master (
        output req_valid,
        output req_dest0,
        output req_dest1,
        output req_dest2,
        output req_data0,
        output req_data1,
        output req_data2,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_dest0,
        input  req_dest1,
        input  req_dest2,
        input  req_data0,
        input  req_data1,
        input  req_data2,
        output req_ready
    );
endinterface

// File: rtl/regfile_port_sched.sv
// Register file write-port scheduler: round-robin write arbitration
// plus a 3-cycle 16-bit register exchange sequencer.
`ifndef REG_SELECT_DEFINED
`define REG_SELECT_DEFINED
`define REG_SEL logic [3:0]
`endif

module regfile_port_sched #(
    parameter int DATA_W   = 16,
    parameter int RR_RESET = 0
) (
    input  logic                clk,
    input  logic                reset,
    regfile_port_sched_if.slave req,
    input  `REG_SEL             rd1_sel,
    input  `REG_SEL             rd2_sel,
    input  logic                xchg_start,
    input  `REG_SEL             xchg_a,
    input  `REG_SEL             xchg_b,
    output logic                xchg_busy,
    output logic                xchg_done,
    output logic                rf_write_en,
    output `REG_SEL             rf_dest,
    output logic [DATA_W-1:0]   rf_in,
    output `REG_SEL             rf_src1,
    output `REG_SEL             rf_src2,
    input  logic [DATA_W-1:0]   rf_out1,
    input  logic [DATA_W-1:0]   rf_out2
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        W1,
        W2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [1:0]        rr_ptr;
    logic [DATA_W-1:0] lat_a;
    logic [DATA_W-1:0] lat_b;
    `REG_SEL           reg_a;
    `REG_SEL           reg_b;

    logic [2:0] rot;
    logic [1:0] off;
    logic [1:0] grant_idx;
    logic [2:0] grant_oh;
    logic       grant_any;
    logic       start_ok;
    logic       xfer;

    assign start_ok = (state == IDLE) && xchg_start;

    // Rotate valids so bit 0 is the requester at rr_ptr.
    always_comb begin
        unique case (rr_ptr)
            2'd1:    rot = {req.req_valid[0], req.req_valid[2],
                            req.req_valid[1]};
            2'd2:    rot = {req.req_valid[1], req.req_valid[0],
                            req.req_valid[2]};
            default: rot = req.req_valid;
        endcase
    end

    always_comb begin
        off = 2'd2;
        if (rot[0])
            off = 2'd0;
        else if (rot[1])
            off = 2'd1;
    end

    always_comb begin
        logic [2:0] sum;
        sum       = {1'b0, rr_ptr} + {1'b0, off};
        grant_idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
        grant_any = |rot;
        grant_oh  = 3'b001 << grant_idx;
    end

    assign xfer = (state == IDLE) && !xchg_start && grant_any;

    // State register and datapath latches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= 2'(RR_RESET);
            lat_a  <= '0;
            lat_b  <= '0;
            reg_a  <= '0;
            reg_b  <= '0;
        end else begin
            state <= next_state;
            if (xfer)
                rr_ptr <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
            if (start_ok) begin
                lat_a <= rf_out1;
                lat_b <= rf_out2;
                reg_a <= xchg_a;
                reg_b <= xchg_b;
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (xchg_start) next_state = CAPTURE;
            CAPTURE: next_state = W1;
            W1:      next_state = W2;
            W2:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req.req_ready = '0;
        rf_write_en   = 1'b0;
        rf_dest       = '0;
        rf_in         = '0;
        rf_src1       = rd1_sel;
        rf_src2       = rd2_sel;
        xchg_busy     = 1'b0;
        xchg_done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (xchg_start) begin
                    rf_src1 = xchg_a;
                    rf_src2 = xchg_b;
                end else if (grant_any) begin
                    req.req_ready = grant_oh;
                    rf_write_en   = 1'b1;
                    unique case (1'b1)
                        grant_oh[1]: begin
                            rf_dest = req.req_dest1;
                            rf_in   = req.req_data1;
                        end
                        grant_oh[2]: begin
                            rf_dest = req.req_dest2;
                            rf_in   = req.req_data2;
                        end
                        default: begin
                            rf_dest = req.req_dest0;
                            rf_in   = req.req_data0;
                        end
                    endcase
                end
            end
            CAPTURE: xchg_busy = 1'b1;
            W1: begin
                xchg_busy   = 1'b1;
                rf_write_en = 1'b1;
                rf_dest     = reg_a;
                rf_in       = lat_b;
            end
            W2: begin
                xchg_busy   = 1'b1;
                rf_write_en = 1'b1;
                rf_dest     = reg_b;
                rf_in       = lat_a;
                xchg_done   = 1'b1;
            end
            default: ;
        endcase
        // The grant path is combinational, so gate it while reset is held.
        if (reset) begin
            req.req_ready = '0;
            rf_write_en   = 1'b0;
            xchg_busy     = 1'b0;
            xchg_done     = 1'b0;
        end
    end

endmodule
